demux8t1_buf: RTL and testbench

- Routes one producer stream to eight consumer channels: the distributing counterpart of the 8:1 select mux.
- Each 32-bit word is steered by a 3-bit select, or broadcast to all channels, into a per-channel one-entry holding register with valid/ready handshake.
- Sits between a single result source (e.g. writeback/forwarding bus) and up to eight pipeline consumers that drain at independent rates.

---
 rtl/demux8t1_buf_pkg.sv | 17 +
 rtl/demux8t1_buf_if.sv | 29 ++
 rtl/demux8t1_buf_slot.sv | 48 ++++
 rtl/demux8t1_buf.sv | 67 ++++++
 tb/tb_demux8t1_buf.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/demux8t1_buf_pkg.sv
// Shared constants and helpers for the 1-to-8 buffered demultiplexer.
// Channel count and select width are tied together; data width matches the mux family.
package demux8t1_buf_pkg;

  localparam int NCH    = 8;
  localparam int SEL_W  = 3;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  function automatic logic [CNT_W-1:0] popcount(input logic [NCH-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < NCH; i++) c += CNT_W'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/demux8t1_buf_if.sv
// Producer and consumer signals of the demultiplexer.
// The slave modport is the demux; the master modport is whoever drives the producer and consumers.
interface demux8t1_buf_if
  import demux8t1_buf_pkg::*;
#(
  parameter int WIDTH = DATA_W
);

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data;
  logic [SEL_W-1:0]     in_sel;
  logic                 in_bcast;
  logic [NCH-1:0]       out_valid;
  logic [NCH-1:0]       out_ready;
  logic [NCH*WIDTH-1:0] out_data;
  logic [CNT_W-1:0]     pending;

  modport slave (
    input  in_valid, in_data, in_sel, in_bcast, out_ready,
    output in_ready, out_valid, out_data, pending
  );

  modport master (
    output in_valid, in_data, in_sel, in_bcast, out_ready,
    input  in_ready, out_valid, out_data, pending
  );

endinterface

// File: rtl/demux8t1_buf_slot.sv
// One-entry holding register for a single output channel.
// A load wins over a same-cycle drain, so a slot never bubbles when refilled while emptying.
module demux8t1_buf_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic             can_acc,
  output logic             valid_q,
  output logic             valid_d,
  output logic [WIDTH-1:0] data_q
);

  logic [WIDTH-1:0] data_d;

  assign can_acc = !valid_q || out_ready;

  // NOTE: every always_comb output takes its hold value first, so no path can infer a latch.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: state uses non-blocking assignments; the data register is reset too because
  // out_data is defined as zero after reset, not merely don't-care.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assert property (@(posedge clk) disable iff (rst)
    (valid_q && !out_ready) |=> $stable(data_q));

endmodule

// File: rtl/demux8t1_buf.sv
// Steers each accepted word to one channel (or all eight on broadcast) with one-cycle latency.
// Only out_ready/in_sel/in_bcast reach in_ready combinationally; data paths are all registered.
module demux8t1_buf
  import demux8t1_buf_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic          clk,
  input  logic          rst,
  demux8t1_buf_if.slave bus
);

  logic [NCH-1:0]       can_acc;
  logic [NCH-1:0]       tgt;
  logic [NCH-1:0]       load;
  logic [NCH-1:0]       valid_q;
  logic [NCH-1:0]       valid_nxt;
  logic [NCH*WIDTH-1:0] data_flat;
  logic                 in_ready;
  logic                 accept;
  logic [CNT_W-1:0]     pending_d;
  logic [CNT_W-1:0]     pending_q;

  always_comb begin
    tgt = '0;
    if (bus.in_bcast) tgt = '1;
    else              tgt[bus.in_sel] = 1'b1;
  end

  // Broadcast is all-or-nothing: every slot must be able to take the word.
  assign in_ready = bus.in_bcast ? &can_acc : can_acc[bus.in_sel];
  assign accept   = bus.in_valid && in_ready;
  assign load     = {NCH{accept}} & tgt;

  for (genvar k = 0; k < NCH; k++) begin : g_slot
    demux8t1_buf_slot #(.WIDTH(WIDTH)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (load[k]),
      .load_data (bus.in_data),
      .out_ready (bus.out_ready[k]),
      .can_acc   (can_acc[k]),
      .valid_q   (valid_q[k]),
      .valid_d   (valid_nxt[k]),
      .data_q    (data_flat[k*WIDTH +: WIDTH])
    );
  end

  // Counting the next-state valids keeps the registered count aligned with out_valid.
  always_comb begin
    pending_d = popcount(valid_nxt);
  end

  always_ff @(posedge clk) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_flat;
  assign bus.pending   = pending_q;

  assert property (@(posedge clk) disable iff (rst)
    (bus.in_valid && !bus.in_bcast) |-> !$isunknown(bus.in_sel));

endmodule

// File: tb/tb_demux8t1_buf.sv
// Directed scenarios plus randomized stress against a channel-occupancy model of the demux.
module tb_demux8t1_buf;

  localparam int W = 32;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  demux8t1_buf_if #(.WIDTH(W)) bus ();

  demux8t1_buf #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fails  = 0;

  // Model: whether each channel holds an undelivered word, and which one.
  bit          exp_v [N];
  logic [W-1:0] exp_d [N];

  function automatic logic [W-1:0] chan(input int k);
    return bus.out_data[k*W +: W];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [2:0] s, input bit b, input logic [W-1:0] d);
    bus.in_valid = v;
    bus.in_sel   = s;
    bus.in_bcast = b;
    bus.in_data  = d;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.out_ready = 8'h00;
    drive(1'b1, 3'd3, 1'b0, 32'h1111_2222);
    step();
    step();
    n_checks++; if (bus.out_valid !== 8'h00) begin n_fails++; $display("FAIL reset_valid got %h want 00", bus.out_valid); end
    n_checks++; if (bus.pending !== 4'd0) begin n_fails++; $display("FAIL reset_pending got %0d want 0", bus.pending); end
    n_checks++; if (bus.out_data !== '0) begin n_fails++; $display("FAIL reset_data got %h want 0", bus.out_data); end
    rst = 1'b0;
    drive(1'b1, 3'd3, 1'b0, 32'hDEAD_BEEF);
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fails++; $display("FAIL first_ready got %b want 1", bus.in_ready); end
    step();
    drive(1'b0, 3'd0, 1'b0, 32'h0);
    n_checks++; if (bus.out_valid !== 8'h08) begin n_fails++; $display("FAIL first_valid got %h want 08", bus.out_valid); end
    n_checks++; if (chan(3) !== 32'hDEAD_BEEF) begin n_fails++; $display("FAIL first_data got %h want deadbeef", chan(3)); end
    n_checks++; if (bus.pending !== 4'd1) begin n_fails++; $display("FAIL first_pending got %0d want 1", bus.pending); end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 8'h00;
    drive(1'b1, 3'd3, 1'b0, 32'h7777_7777);
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fails++; $display("FAIL bp_ready got %b want 0", bus.in_ready); end
    step();
    n_checks++; if (chan(3) !== 32'hDEAD_BEEF) begin n_fails++; $display("FAIL bp_hold got %h want deadbeef", chan(3)); end
    drive(1'b1, 3'd5, 1'b0, 32'h5);
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fails++; $display("FAIL bp_other_ready got %b want 1", bus.in_ready); end
    step();
    drive(1'b0, 3'd0, 1'b0, 32'h0);
    n_checks++; if (bus.out_valid !== 8'h28) begin n_fails++; $display("FAIL bp_valid got %h want 28", bus.out_valid); end
    n_checks++; if (bus.pending !== 4'd2) begin n_fails++; $display("FAIL bp_pending got %0d want 2", bus.pending); end
    n_checks++; if (chan(5) !== 32'h5) begin n_fails++; $display("FAIL bp_data5 got %h want 5", chan(5)); end
  endtask

  task automatic test_drain_load();
    bus.out_ready = 8'h08;
    drive(1'b1, 3'd3, 1'b0, 32'h1234);
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fails++; $display("FAIL dl_ready got %b want 1", bus.in_ready); end
    step();
    bus.out_ready = 8'h00;
    drive(1'b0, 3'd0, 1'b0, 32'h0);
    n_checks++; if (bus.out_valid !== 8'h28) begin n_fails++; $display("FAIL dl_valid got %h want 28", bus.out_valid); end
    n_checks++; if (chan(3) !== 32'h1234) begin n_fails++; $display("FAIL dl_data got %h want 1234", chan(3)); end
    n_checks++; if (bus.pending !== 4'd2) begin n_fails++; $display("FAIL dl_pending got %0d want 2", bus.pending); end
  endtask

  task automatic test_broadcast();
    drive(1'b1, 3'd0, 1'b0, 32'h0000_00C0);
    step();
    drive(1'b1, 3'd6, 1'b1, 32'hA5A5_A5A5);
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fails++; $display("FAIL bc_blocked got %b want 0", bus.in_ready); end
    step();
    n_checks++; if (bus.out_valid !== 8'h29) begin n_fails++; $display("FAIL bc_noload_valid got %h want 29", bus.out_valid); end
    n_checks++; if (chan(3) !== 32'h1234) begin n_fails++; $display("FAIL bc_noload_data got %h want 1234", chan(3)); end
    bus.out_ready = 8'hFF;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fails++; $display("FAIL bc_ready got %b want 1", bus.in_ready); end
    step();
    bus.out_ready = 8'h00;
    drive(1'b0, 3'd0, 1'b0, 32'h0);
    n_checks++; if (bus.out_valid !== 8'hFF) begin n_fails++; $display("FAIL bc_valid got %h want ff", bus.out_valid); end
    n_checks++; if (bus.pending !== 4'd8) begin n_fails++; $display("FAIL bc_pending got %0d want 8", bus.pending); end
    for (int k = 0; k < N; k++) begin
      n_checks++; if (chan(k) !== 32'hA5A5_A5A5) begin n_fails++; $display("FAIL bc_data%0d got %h want a5a5a5a5", k, chan(k)); end
    end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 8'h04;
    drive(1'b1, 3'd2, 1'b0, 32'hCAFE_F00D);
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fails++; $display("FAIL rm_ready got %b want 1", bus.in_ready); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.out_ready = 8'h00;
    drive(1'b0, 3'd0, 1'b0, 32'h0);
    n_checks++; if (bus.out_valid !== 8'h00) begin n_fails++; $display("FAIL rm_valid got %h want 00", bus.out_valid); end
    n_checks++; if (bus.pending !== 4'd0) begin n_fails++; $display("FAIL rm_pending got %0d want 0", bus.pending); end
    n_checks++; if (bus.out_data !== '0) begin n_fails++; $display("FAIL rm_data got %h want 0", bus.out_data); end
    step();
    n_checks++; if (bus.out_valid !== 8'h00) begin n_fails++; $display("FAIL rm_inflight got %h want 00", bus.out_valid); end
  endtask

  task automatic test_random(input int cycles);
    bit           blocked;
    bit           exp_rdy;
    int           occ;
    logic [N-1:0] want_v;
    for (int k = 0; k < N; k++) begin
      exp_v[k] = 1'b0;
      exp_d[k] = '0;
    end
    blocked = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      occ = 0;
      for (int k = 0; k < N; k++) begin
        want_v[k] = exp_v[k];
        if (exp_v[k]) occ++;
      end
      n_checks++; if (bus.out_valid !== want_v) begin n_fails++; $display("FAIL rnd_valid cyc %0d got %h want %h", c, bus.out_valid, want_v); end
      n_checks++; if (int'(bus.pending) != occ) begin n_fails++; $display("FAIL rnd_pending cyc %0d got %0d want %0d", c, bus.pending, occ); end
      // Producer keeps an offered-but-refused word stable; otherwise a fresh one.
      if (!blocked) begin
        bus.in_valid = ($urandom_range(3) != 0);
        bus.in_sel   = 3'($urandom_range(7));
        bus.in_bcast = ($urandom_range(9) == 0);
        bus.in_data  = $urandom;
      end
      bus.out_ready = 8'($urandom);
      #1;
      if (bus.in_bcast) begin
        exp_rdy = 1'b1;
        for (int k = 0; k < N; k++) if (exp_v[k] && !bus.out_ready[k]) exp_rdy = 1'b0;
      end else begin
        exp_rdy = !exp_v[bus.in_sel] || bus.out_ready[bus.in_sel];
      end
      n_checks++; if (bus.in_ready !== exp_rdy) begin n_fails++; $display("FAIL rnd_ready cyc %0d got %b want %b", c, bus.in_ready, exp_rdy); end
      // Each consumed word must be the one most recently delivered to that channel.
      for (int k = 0; k < N; k++) begin
        if (exp_v[k] && bus.out_ready[k]) begin
          n_checks++; if (chan(k) !== exp_d[k]) begin n_fails++; $display("FAIL rnd_data ch %0d cyc %0d got %h want %h", k, c, chan(k), exp_d[k]); end
          exp_v[k] = 1'b0;
        end
      end
      if (bus.in_valid && exp_rdy) begin
        for (int k = 0; k < N; k++) begin
          if (bus.in_bcast || (int'(bus.in_sel) == k)) begin
            exp_v[k] = 1'b1;
            exp_d[k] = bus.in_data;
          end
        end
      end
      blocked = bus.in_valid && !exp_rdy;
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 8'h00;
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_sel    = 3'd0;
    bus.in_bcast  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 8'h00;
    test_reset();
    test_backpressure();
    test_drain_load();
    test_broadcast();
    test_reset_mid();
    test_random(10000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
